// File: rtl/booth_mul_32_bit.sv
// Sequential radix-4 Booth multiplier (signed or unsigned) producing a 2*WIDTH-bit
// product as {hi, lo}. One Booth digit is retired per clock; the result appears
// N = WIDTH/2 clocks after the start edge with a one-cycle done pulse.
//
// Operands are extended to WIDTH+2 bits, so the Booth recoding of the multiplier
// needs N+1 digits. The topmost digit is 0 for signed operands and +A when an
// unsigned multiplier has its MSB set. The first digit is retired on the start edge
// itself, using the shared adder, which is otherwise idle in IDLE. The remaining N
// digits then fit in the N CALC edges, which keeps the latency fixed at N.
module booth_mul_32_bit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int EW = WIDTH + 2;
  localparam int N  = WIDTH / 2;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic {IDLE, CALC} state_t;

  state_t               state_q;
  logic signed [EW-1:0] a_q;
  logic signed [EW-1:0] acc_q;
  logic        [EW:0]   sh_q;
  logic        [CW-1:0] cnt_q;
  logic [WIDTH-1:0]     hi_q;
  logic [WIDTH-1:0]     lo_q;
  logic                 busy_q;
  logic                 done_q;

  logic signed [EW-1:0] a_ext;
  logic        [EW-1:0] b_ext;
  logic signed [EW-1:0] a_sel;
  logic signed [EW-1:0] acc_sel;
  logic        [EW:0]   sh_sel;
  logic signed [EW-1:0] addend;
  logic                 neg;
  logic signed [EW-1:0] sum;
  logic signed [EW-1:0] acc_d;
  logic        [EW:0]   sh_d;
  logic [WIDTH-1:0]     hi_d;
  logic [WIDTH-1:0]     lo_d;

  // Booth digit decode. Returns {negate, operand}, where operand is already
  // inverted for negative digits; the negate bit then acts as the adder carry-in,
  // so one adder serves both +/-A and +/-2A.
  function automatic logic [EW:0] booth_addend(input logic [2:0] bits,
                                               input logic [EW-1:0] a);
    logic [EW-1:0] mag;
    logic          ng;
    mag = '0;
    ng  = 1'b0;
    case (bits)
      3'b001, 3'b010: mag = a;
      3'b011:         mag = {a[EW-2:0], 1'b0};
      3'b100: begin
        mag = {a[EW-2:0], 1'b0};
        ng  = 1'b1;
      end
      3'b101, 3'b110: begin
        mag = a;
        ng  = 1'b1;
      end
      default:        mag = '0;
    endcase
    return {ng, (ng ? ~mag : mag)};
  endfunction

  // Shared datapath: select operands (fresh inputs in IDLE, latched state in CALC),
  // add one Booth digit and arithmetic-shift {acc, sh} right by two.
  always_comb begin
    a_ext = is_signed ? {{2{multiplicand[WIDTH-1]}}, multiplicand} : {2'b00, multiplicand};
    b_ext = is_signed ? {{2{multiplier[WIDTH-1]}}, multiplier} : {2'b00, multiplier};
    if (state_q == IDLE) begin
      a_sel   = a_ext;
      acc_sel = '0;
      sh_sel  = {b_ext, 1'b0};
    end else begin
      a_sel   = a_q;
      acc_sel = acc_q;
      sh_sel  = sh_q;
    end
    {neg, addend} = booth_addend(sh_sel[2:0], a_sel);
    sum   = acc_sel + addend + EW'(neg);
    acc_d = {{2{sum[EW-1]}}, sum[EW-1:2]};
    sh_d  = {sum[1:0], sh_sel[EW:2]};
    hi_d  = {acc_d[WIDTH-3:0], sh_d[EW:EW-1]};
    lo_d  = sh_d[WIDTH:1];
  end

  // Control FSM and datapath registers; the result is registered on the last digit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      acc_q   <= '0;
      sh_q    <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= a_ext;
            acc_q   <= acc_d;
            sh_q    <= sh_d;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          acc_q <= acc_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST) begin
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
